// File: rtl/manchester_preamble_strip.sv
// Receive-side preamble/SFD stripper for the Manchester byte stream.
// Hunts each burst for PRE_MIN or more preamble bytes followed by the SFD,
// then forwards the payload through a single output register with tlast
// preserved. Bursts that end without delivering payload count as drops.
module manchester_preamble_strip #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PRE_BYTE   = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] SFD_BYTE   = 8'hD5,
    parameter int                    PRE_MIN    = 2,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam logic [3:0] PRE_MIN_C = 4'(PRE_MIN);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              pre_cnt, pre_cnt_nxt;
    logic                    frame_inc, drop_inc;
    logic                    accept, load;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    last_p1;
    logic                    vld_p1;

    function automatic logic [3:0] sat_inc_pre(input logic [3:0] v);
        return (&v) ? v : v + 4'd1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // While hunting nothing is forwarded, so input is always accepted; in
    // payload the single output register must be free or draining.
    assign s_axis_tready = (state == HUNT) | !vld_p1 | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load          = accept & (state == PAYLOAD);

    // Next-state, preamble run length and counter strobes from each accepted beat.
    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        frame_inc   = 1'b0;
        drop_inc    = 1'b0;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (s_axis_tlast) begin
                        // Burst ended before any payload, even right after a good SFD.
                        drop_inc    = 1'b1;
                        pre_cnt_nxt = 4'd0;
                    end else if (s_axis_tdata == PRE_BYTE) begin
                        pre_cnt_nxt = sat_inc_pre(pre_cnt);
                    end else if ((s_axis_tdata == SFD_BYTE) && (pre_cnt >= PRE_MIN_C)) begin
                        state_nxt   = PAYLOAD;
                        pre_cnt_nxt = 4'd0;
                    end else begin
                        pre_cnt_nxt = 4'd0;
                    end
                end
                PAYLOAD: begin
                    if (s_axis_tlast) begin
                        frame_inc = 1'b1;
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // State, preamble counter and status counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= HUNT;
            pre_cnt   <= 4'd0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_cnt_nxt;
            if (frame_inc) frame_cnt <= sat_inc_cnt(frame_cnt);
            if (drop_inc)  drop_cnt  <= sat_inc_cnt(drop_cnt);
        end
    end

    // Output stage: load on accepted payload beat, hold while stalled, empty on handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            data_p1 <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            data_p1 <= s_axis_tdata;
            last_p1 <= s_axis_tlast;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && m_axis_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign m_axis_tdata  = data_p1;
    assign m_axis_tlast  = last_p1;
    assign m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_manchester_preamble_strip.sv
// Directed bench for manchester_preamble_strip: drives bursts from one
// initial block and compares collected output beats and counters.
module tb_manchester_preamble_strip;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int bp_idx = 0;
    logic bp_en = 1'b0;
    logic pl_phase = 1'b0;
    logic stall_prev = 1'b0;
    logic [8:0] held = 9'h0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    manchester_preamble_strip dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Compare one observed value against its expectation and report a mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: held high, or cycling 1,0,0,1 when backpressure is on.
    always @(posedge aclk) begin
        #2;
        if (bp_en) begin
            m_axis_tready = ((bp_idx % 4) == 1 || (bp_idx % 4) == 2) ? 1'b0 : 1'b1;
            bp_idx++;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    // Output monitor: records beats that handshake at the next edge, checks stall behaviour.
    always @(negedge aclk) begin
        if (areset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", m_axis_tvalid, 1'b1);
                check("stall_data", {m_axis_tlast, m_axis_tdata}, held);
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
            if (pl_phase && m_axis_tvalid && !m_axis_tready) check("stall_s_ready", s_axis_tready, 1'b0);
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tlast, m_axis_tdata};
        end
    end

    // Present one beat (called at a falling edge) and wait for it to be accepted.
    task automatic send(input logic [7:0] d, input logic l, input logic chk);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("accept_timeout", (n < 100), 1'b1);
        @(posedge aclk);
        #1;
        if (chk) begin
            check("out_valid_after_accept", m_axis_tvalid, 1'b1);
            check("out_beat_after_accept", {m_axis_tlast, m_axis_tdata}, {l, d});
        end
        if (l) pl_phase = 1'b0;
        @(negedge aclk);
    endtask

    // Full frame: two preamble bytes, SFD, then len payload bytes counting up from first.
    task automatic frame(input logic [7:0] first, input int len);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        pl_phase = 1'b1;
        for (int i = 0; i < len; i++) begin
            send(8'(first + 8'(i)), (i == len - 1), 1'b1);
            exp_q.push_back({(i == len - 1), 8'(first + 8'(i))});
        end
    endtask

    // Stop driving, let the output register empty, and compare what was delivered.
    task automatic drain_compare(input string tag);
        int n;
        n = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        while (m_axis_tvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("drain_timeout", (n < 50), 1'b1);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_beat"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int c0;

        // Reset state
        @(posedge aclk);
        #1;
        check("rst_m_valid", m_axis_tvalid, 1'b0);
        check("rst_m_data", m_axis_tdata, 8'h00);
        check("rst_m_last", m_axis_tlast, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        check("rst_s_ready", s_axis_tready, 1'b1);
        @(posedge aclk);
        #3 areset = 1'b0;
        @(negedge aclk);

        // Basic frame
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        pl_phase = 1'b1;
        send(8'h11, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h11});
        send(8'h22, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h22});
        send(8'h33, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h33});
        send(8'h44, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h44});
        send(8'h55, 1'b1, 1'b1); exp_q.push_back({1'b1, 8'h55});
        check("basic_frame_cnt", frame_cnt, 16'd1);
        check("basic_drop_cnt", drop_cnt, 16'd0);
        drain_compare("basic");

        // Back-to-back frames at full rate
        c0 = cyc;
        frame(8'h00, 8);
        frame(8'h08, 8);
        frame(8'h10, 8);
        frame(8'h18, 8);
        check("b2b_cycles", cyc - c0, 44);
        drain_compare("b2b");
        check("b2b_frame_cnt", frame_cnt, 16'd5);

        // Noise, then short preamble run followed by a good one
        send(8'h13, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        check("noise_drop_cnt", drop_cnt, 16'd1);
        send(8'hAA, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        pl_phase = 1'b1;
        send(8'h66, 1'b1, 1'b1); exp_q.push_back({1'b1, 8'h66});
        drain_compare("noise");
        check("noise_frame_cnt", frame_cnt, 16'd6);
        check("noise_drop_cnt2", drop_cnt, 16'd1);

        // Empty and truncated frames
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b1, 1'b0);
        check("empty_drop_cnt", drop_cnt, 16'd2);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        check("trunc_drop_cnt", drop_cnt, 16'd3);
        check("trunc_hunt_ready", s_axis_tready, 1'b1);
        drain_compare("empty");
        check("empty_frame_cnt", frame_cnt, 16'd6);

        // Backpressure on the basic frame
        bp_en = 1'b1;
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        pl_phase = 1'b1;
        send(8'h11, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h11});
        send(8'h22, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h22});
        send(8'h33, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h33});
        send(8'h44, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h44});
        send(8'h55, 1'b1, 1'b1); exp_q.push_back({1'b1, 8'h55});
        drain_compare("bp");
        check("bp_frame_cnt", frame_cnt, 16'd7);
        bp_en = 1'b0;
        @(negedge aclk);
        @(negedge aclk);

        // Payload that looks like preamble/SFD
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        pl_phase = 1'b1;
        send(8'hAA, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'hAA});
        send(8'hD5, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'hD5});
        send(8'hAA, 1'b1, 1'b1); exp_q.push_back({1'b1, 8'hAA});
        drain_compare("lookalike");
        check("lookalike_frame_cnt", frame_cnt, 16'd8);

        // Reset in the middle of a payload
        send(8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hD5, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b1);
        send(8'h02, 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        #1 areset = 1'b1;
        #1;
        check("midrst_m_valid", m_axis_tvalid, 1'b0);
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        check("midrst_drop_cnt", drop_cnt, 16'd0);
        check("midrst_s_ready", s_axis_tready, 1'b1);
        @(posedge aclk);
        #3 areset = 1'b0;
        got_q.delete();
        @(negedge aclk);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b1, 1'b0);
        drain_compare("remainder");
        check("remainder_drop_cnt", drop_cnt, 16'd1);
        frame(8'h99, 2);
        drain_compare("post_rst");
        check("post_rst_frame_cnt", frame_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/manchester_preamble_strip.md
# manchester_preamble_strip

Receive-side counterpart to the transmit preamble inserter. It accepts the byte stream recovered by the Manchester decoder and hunts each frame for the preamble run `0xAA` followed by the start-of-frame delimiter `0xD5`. It strips those bytes and forwards only the payload on an AXI-Stream master, with `tlast` preserved on the final payload byte. Frames that are noise or too short are dropped, and saturating counters record delivered and dropped frames.

## Interface
- `DATA_WIDTH`, 8: byte width of the stream; only 8 is supported.
- `PRE_BYTE`, 8'hAA: preamble byte value.
- `SFD_BYTE`, 8'hD5: start-of-frame delimiter value.
- `PRE_MIN`, 2: minimum consecutive `PRE_BYTE`s before `SFD_BYTE`; range 1..15.
- `CNT_WIDTH`, 16: width of the status counters.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  received byte.
- `s_axis_tvalid`  in  1  input byte valid.
- `s_axis_tready`  out  1  input accept.
- `s_axis_tlast`  in  1  last byte of the received burst (carrier drop or frame end).
- `m_axis_tdata`  out  DATA_WIDTH  payload byte.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  last payload byte of the frame.
- `frame_cnt`  out  CNT_WIDTH  frames delivered, saturating.
- `drop_cnt`  out  CNT_WIDTH  input bursts ended without delivering payload, saturating.

## Operation
- An input beat is accepted when `s_axis_tvalid & s_axis_tready`. The FSM advances only on accepted beats.
- The FSM has two states, HUNT and PAYLOAD. A 4-bit saturating `pre_cnt` counts `PRE_BYTE`s seen while in HUNT.
- **HUNT** (bytes are never forwarded):
  - byte == `PRE_BYTE`: `pre_cnt` increments, saturating at 15.
  - byte == `SFD_BYTE` with `pre_cnt >= PRE_MIN` and `tlast` = 0: go to PAYLOAD and clear `pre_cnt`.
  - any other byte, or `SFD_BYTE` with `pre_cnt < PRE_MIN`: clear `pre_cnt`.
  - `tlast` = 1 on any HUNT beat, including a valid `SFD_BYTE` (empty payload): `drop_cnt` increments, `pre_cnt` clears, state stays HUNT.
- **PAYLOAD**:
  - Every accepted byte is loaded into the output register with its `tlast`.
  - Byte values are not inspected, so `0xAA` and `0xD5` are legal payload.
  - `tlast` = 1: `frame_cnt` increments and the state returns to HUNT.
- **Ready rule**:
  - `s_axis_tready` = 1 in HUNT.
  - `s_axis_tready` = `!m_axis_tvalid | m_axis_tready` in PAYLOAD.
- **Output register**:
  - Loads on each accepted PAYLOAD beat.
  - `m_axis_tvalid` clears on a handshake with no new load.
  - `m_axis_tdata` and `m_axis_tlast` hold steady while `m_axis_tvalid & !m_axis_tready`.
- **Counters**: saturate at all-ones and never wrap.

## Timing
- **Reset values**: state HUNT, `pre_cnt` 0, `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0, `frame_cnt` 0, `drop_cnt` 0. `s_axis_tready` is 1 combinationally during and after reset, because the state is HUNT.
- **Latency**: a payload byte accepted at edge N has `m_axis_tvalid` = 1 after edge N. Throughput is one byte per cycle with `m_axis_tready` held high.
- **Counter update**: `frame_cnt` and `drop_cnt` update on the edge that accepts the `tlast` beat, not on the output handshake.
- **Frame boundary**: on the PAYLOAD→HUNT edge the output register may still hold the last byte. HUNT beats are accepted meanwhile, because `s_axis_tready` = 1 and nothing is loaded. A new PAYLOAD's first byte waits for the register to free.
- **Back-to-back frames**: the next frame's preamble may follow the previous `tlast` with zero idle cycles.
- **Reset mid-frame**: the output beat is lost, the counters clear, and the remainder of the frame is hunted and will not match unless it contains a full preamble.
- **Backpressure**: `m_axis_tready` low in PAYLOAD stalls input after one buffered byte. Data and `tlast` are never dropped or duplicated.

## Test plan
- **Basic frame**: send AA AA D5 11 22 33 44 55(last), `m_axis_tready` = 1 → output 11 22 33 44 55 with `tlast` on 55 only; `frame_cnt` = 1, `drop_cnt` = 0; each byte appears 1 cycle after its input accept.
- **Back-to-back frames**: four frames of AA AA D5 followed by 8 bytes (00..07, 08..0F, 10..17, 18..1F, `tlast` on 07/0F/17/1F), no idle between frames → output 00..1F contiguous, `tlast` on 07, 0F, 17, 1F; `frame_cnt` = 4.
- **Noise and short preamble**: send 13 AA D5 77(last), then AA 00 AA AA AA D5 66(last) → first burst produces no output, `drop_cnt` = 1; second burst outputs 66 with `tlast`, because 3 ≥ `PRE_MIN`.
- **Empty and truncated frames**: AA AA D5(last) → no output, `drop_cnt` +1; AA AA(last) → no output, `drop_cnt` +1; state returns to HUNT in both cases.
- **Backpressure**: basic frame with `m_axis_tready` toggling 1,0,0,1 repeatedly → output sequence identical to the basic-frame case, `m_axis_tdata` stable while stalled, `s_axis_tready` = 0 whenever `m_axis_tvalid & !m_axis_tready` in PAYLOAD.
- **Payload lookalikes and reset**: AA AA D5 AA D5 AA(last) → output AA D5 AA. Then assert `areset` after 2 payload bytes of a new frame → `m_axis_tvalid` = 0 and counters 0 immediately; the following full frame is received correctly.
